uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised next-generation UART transmitter. It serialises DATA_WIDTH-bit words LSB-first with runtime-selectable parity (none/even/odd) and 1 or 2 stop bits. A one-word holding register lets the upstream queue the next word while the current frame is shifting, so back-to-back frames have no idle gap. It sits between a valid/ready byte source and the tx pin.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..16)
CLOCK_FREQ, 90, clock frequency in Hz
BAUD_RATE, 30, bit rate in bit/s
DIV, CLOCK_FREQ/BAUD_RATE, clocks per bit; elaboration error if DIV < 2
DIV_WIDTH, 16, bit-period counter width; must satisfy DIV <= 2**DIV_WIDTH-1

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
data  input  DATA_WIDTH  word to transmit
valid  input  1  data valid
ready  output  1  holding register empty; transfer on valid && ready at rising clk
parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none
stop_bits  input  1  0 = one stop bit, 1 = two stop bits
tx  output  1  serial line, idle high
busy  output  1  frame in progress (state != IDLE)
frame_done  output  1  one-cycle pulse on the last clock of the final stop bit

Behaviour:
- Reset (reset_n low, async): tx=1, ready=1, busy=0, frame_done=0, holding register empty, state IDLE, all counters 0. Reset mid-frame aborts the frame immediately; tx returns to 1 without a glitch to 0.
- All outputs are registered. None is combinational from inputs.
- Holding register: loaded on the accept edge E. ready=0 from E until the word is moved into the shift register.
- Transfer to shift register: occurs in IDLE when hold is full, or on the frame_done cycle when hold is full. On that same edge, parity_mode and stop_bits are sampled into frame-local registers. A config change mid-frame has no effect on the current frame.
- Latency: word accepted at edge E while IDLE gives state START, tx=0, and ready=1 after edge E+1.
- States:
  - IDLE: tx=1.
  - START: tx=0 for DIV clocks.
  - DATA: tx=shift[0] for DIV clocks per bit. Shift right at each bit boundary. Bit counter 0..DATA_WIDTH-1.
  - PARITY: present only if the sampled mode is 01 or 10. tx = ^word (even) or ~^word (odd) for DIV clocks.
  - STOP: tx=1 for DIV clocks, or 2*DIV clocks if stop_bits was 1.
- Transitions: IDLE->START when hold is full. START->DATA at end of bit. DATA->PARITY or STOP after bit DATA_WIDTH-1. PARITY->STOP. STOP->START if hold is full at the end of the last stop clock, otherwise STOP->IDLE.
- Bit-period counter: counts 0..DIV-1 and clears at every bit boundary and on every state entry. Each bit lasts exactly DIV clocks with no drift.
- Frame length: DIV*(1+DATA_WIDTH+P+S) clocks, where P is 0/1 and S is 1/2.
- Back-to-back: with hold full at frame_done, the next start bit begins on the following clock. No idle clock is inserted.
- ready rises on the transfer edge. The upstream may therefore queue the next word during the START bit of the current frame.
- valid with ready=0 is ignored. data is only sampled on an accept edge, so the upstream need not hold data after the accept.
- busy goes high with START and falls on the edge that returns to IDLE.

Test Plan:
- DIV=4 (CLOCK_FREQ=40, BAUD_RATE=10), mode 00, stop 0, send 8'hA5 from idle -> ready low 1 cycle. tx after start: 0 for 4 clocks, then 1,0,1,0,0,1,0,1 (4 clocks each), then 1 for 4 clocks. Frame = 40 clocks; frame_done pulses on clock 40; busy 40 clocks.
- Same word, mode 01 (even) then 10 (odd) -> parity bit 0 then 1. Frame = 44 clocks each.
- stop_bits=1, mode 00, 8'hFF -> stop high for 8 clocks; frame = 44 clocks.
- Two words 8'h01 and 8'h80, valid held high, second accepted during the first frame's START -> second start bit begins on the clock after the first frame_done; zero idle clocks; ready high before the first frame ends.
- Change parity_mode from 00 to 01 mid-frame -> current frame has no parity bit; next frame sampled with 01 carries one.
- Assert reset_n low during DATA bit 3 -> tx=1, ready=1, busy=0 immediately. After release, a new word produces a clean full frame.

Source files
------------

// File: rtl/uart_tx_cfg_if.sv
// Byte-source handshake into the UART transmitter: data qualified by valid,
// accepted on any rising clock where valid && ready.
interface uart_tx_cfg_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter: LSB-first frames with runtime parity/stop selection and a
// one-word holding register so consecutive frames run with no idle gap.
module uart_tx_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int CLOCK_FREQ = 90,
    parameter int BAUD_RATE  = 30,
    parameter int DIV        = CLOCK_FREQ / BAUD_RATE,
    parameter int DIV_WIDTH  = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    uart_tx_cfg_if.slave in_if,
    input  logic [1:0]   parity_mode_i,
    input  logic         stop_bits_i,
    output logic         tx_o,
    output logic         busy_o,
    output logic         frame_done_o
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [DIV_WIDTH-1:0] CNT_LAST = DIV_WIDTH'(DIV - 1);
    localparam logic [BW-1:0]        BIT_LAST = BW'(DATA_WIDTH - 1);

    if (DIV < 2) begin : g_div_lo
        $error("uart_tx_cfg: DIV must be at least 2");
    end
    if (DIV > 2**DIV_WIDTH - 1) begin : g_div_hi
        $error("uart_tx_cfg: DIV does not fit in DIV_WIDTH");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 16) begin : g_dw
        $error("uart_tx_cfg: DATA_WIDTH must be 5..16");
    end

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

    state_e                state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  par_en_q, par_en_d;
    logic                  par_q, par_d;
    logic                  two_stop_q, two_stop_d;
    logic                  ready_q, ready_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  end_bit;
    logic                  load;

    assign end_bit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_en_q    <= 1'b0;
            par_q       <= 1'b0;
            two_stop_q  <= 1'b0;
            ready_q     <= 1'b1;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            par_en_q    <= par_en_d;
            par_q       <= par_d;
            two_stop_q  <= two_stop_d;
            ready_q     <= ready_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        par_en_d    = par_en_q;
        par_d       = par_q;
        two_stop_d  = two_stop_q;
        load        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                load  = hold_full_q;
            end
            ST_START: begin
                if (end_bit) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (end_bit) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (end_bit) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (end_bit) begin
                    cnt_d = '0;
                    if (two_stop_q && bit_q == '0) begin
                        bit_d = BW'(1);
                    end else if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame config is latched with the word so mid-frame changes only hit the next frame.
        if (load) begin
            state_d     = ST_START;
            cnt_d       = '0;
            bit_d       = '0;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            par_en_d    = (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
            par_d       = (parity_mode_i == 2'b10) ? ~^hold_q : ^hold_q;
            two_stop_d  = stop_bits_i;
        end

        if (in_if.valid && ready_q) begin
            hold_d      = in_if.data;
            hold_full_d = 1'b1;
        end

        ready_d = ~hold_full_d;
        busy_d  = (state_d != ST_IDLE);

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase

        // Registered pulse: flag the clock that will be the last one of the final stop bit.
        done_d = (state_d == ST_STOP) && (cnt_d == CNT_LAST) &&
                 (!two_stop_d || bit_d == BW'(1));
    end

    assign in_if.ready  = ready_q;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: drives words through the handshake and compares the tx
// line clock-by-clock against a per-bit frame model.
module tb_uart_tx_cfg;

    localparam int DW  = 8;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] parity_mode;
    logic       stop_bits;
    logic       tx, busy, frame_done;

    int nerr = 0;
    int nchk = 0;

    logic [DW-1:0] src_q[$];
    bit            exp_q[$];
    bit            fd_q[$];

    uart_tx_cfg_if #(.DATA_WIDTH(DW)) ifc ();

    uart_tx_cfg #(
        .DATA_WIDTH(DW),
        .CLOCK_FREQ(40),
        .BAUD_RATE (10),
        .DIV_WIDTH (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_if        (ifc.slave),
        .parity_mode_i(parity_mode),
        .stop_bits_i  (stop_bits),
        .tx_o         (tx),
        .busy_o       (busy),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and update the source: a word is consumed
    // when valid && ready held across the rising edge in between.
    task automatic tick();
        bit acc;
        acc = (ifc.valid === 1'b1) && (ifc.ready === 1'b1);
        @(negedge clk);
        if (acc && src_q.size() > 0) void'(src_q.pop_front());
        if (src_q.size() > 0) begin
            ifc.valid = 1'b1;
            ifc.data  = src_q[0];
        end else begin
            ifc.valid = 1'b0;
            ifc.data  = DW'($urandom);
        end
    endtask

    // Line levels of one frame, one entry per bit, expanded to DIV clocks each.
    task automatic push_frame(input logic [DW-1:0] w, input logic [1:0] m, input logic s);
        bit lv[$];
        int ones;
        ones = $countones(w);
        lv.push_back(1'b0);
        for (int b = 0; b < DW; b++) lv.push_back(w[b]);
        if (m == 2'b01) lv.push_back(bit'(ones % 2));
        else if (m == 2'b10) lv.push_back(bit'(1 - ones % 2));
        lv.push_back(1'b1);
        if (s) lv.push_back(1'b1);
        foreach (lv[k]) begin
            for (int c = 0; c < DIV; c++) begin
                exp_q.push_back(lv[k]);
                fd_q.push_back(1'b0);
            end
        end
        fd_q[fd_q.size() - 1] = 1'b1;
    endtask

    // Called at the falling edge of frame clock 0; n < 0 checks the whole queue.
    task automatic check_stream(input string tag, input int n, input logic rdy1,
                                input int chg_at, input logic [1:0] chg_mode);
        int lim;
        lim = (n < 0) ? exp_q.size() : n;
        for (int i = 0; i < lim; i++) begin
            check({tag, "/tx"}, tx, exp_q[i]);
            check({tag, "/busy"}, busy, 1'b1);
            check({tag, "/done"}, frame_done, fd_q[i]);
            if (i == 0) check({tag, "/rdy0"}, ifc.ready, 1'b1);
            if (i == 1) check({tag, "/rdy1"}, ifc.ready, rdy1);
            if (i == chg_at) parity_mode = chg_mode;
            tick();
        end
        if (n < 0) begin
            exp_q.delete();
            fd_q.delete();
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "/idle_tx"}, tx, 1'b1);
        check({tag, "/idle_busy"}, busy, 1'b0);
        check({tag, "/idle_done"}, frame_done, 1'b0);
        check({tag, "/idle_rdy"}, ifc.ready, 1'b1);
    endtask

    task automatic send_one(input string tag, input logic [DW-1:0] w,
                            input logic [1:0] m, input logic s);
        parity_mode = m;
        stop_bits   = s;
        src_q.push_back(w);
        push_frame(w, m, s);
        tick();
        check({tag, "/acc_rdy"}, ifc.ready, 1'b1);
        tick();
        check({tag, "/hold_rdy"}, ifc.ready, 1'b0);
        check({tag, "/hold_tx"}, tx, 1'b1);
        tick();
        check_stream(tag, -1, 1'b1, -1, 2'b00);
        check_idle(tag);
    endtask

    task automatic send_two(input string tag, input logic [DW-1:0] w1, input logic [DW-1:0] w2,
                            input logic [1:0] m, input logic s,
                            input int chg_at, input logic [1:0] chg_mode);
        parity_mode = m;
        stop_bits   = s;
        src_q.push_back(w1);
        src_q.push_back(w2);
        push_frame(w1, m, s);
        push_frame(w2, (chg_at >= 0) ? chg_mode : m, s);
        tick();
        tick();
        check({tag, "/hold_rdy"}, ifc.ready, 1'b0);
        check({tag, "/hold_busy"}, busy, 1'b0);
        tick();
        check_stream(tag, -1, 1'b0, chg_at, chg_mode);
        check_idle(tag);
    endtask

    initial begin
        logic [DW-1:0] w;
        reset_n     = 1'b0;
        ifc.valid   = 1'b0;
        ifc.data    = '0;
        parity_mode = 2'b00;
        stop_bits   = 1'b0;
        repeat (3) tick();
        check("rst/tx", tx, 1'b1);
        check("rst/rdy", ifc.ready, 1'b1);
        check("rst/busy", busy, 1'b0);
        check("rst/done", frame_done, 1'b0);
        reset_n = 1'b1;
        repeat (2) tick();
        check_idle("post_rst");

        send_one("a5_none", 8'hA5, 2'b00, 1'b0);
        send_one("a5_even", 8'hA5, 2'b01, 1'b0);
        send_one("a5_odd",  8'hA5, 2'b10, 1'b0);
        send_one("ff_2stop", 8'hFF, 2'b00, 1'b1);
        send_one("mode11", 8'h3C, 2'b11, 1'b0);
        send_two("b2b", 8'h01, 8'h80, 2'b00, 1'b0, -1, 2'b00);
        send_two("cfg_chg", 8'h5A, 8'h5B, 2'b00, 1'b0, 5, 2'b01);

        for (int k = 0; k < 6; k++)
            send_one("rnd1", DW'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        for (int k = 0; k < 3; k++)
            send_two("rnd2", DW'($urandom), DW'($urandom), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), -1, 2'b00);

        // Abort mid-frame: bit 3 forced low so the line visibly returns high.
        parity_mode = 2'b00;
        stop_bits   = 1'b0;
        w = DW'($urandom) & 8'hF7;
        src_q.push_back(w);
        push_frame(w, 2'b00, 1'b0);
        repeat (3) tick();
        check_stream("pre_rst", 18, 1'b1, -1, 2'b00);
        check("pre_rst/tx_bit3", tx, 1'b0);
        check("pre_rst/busy", busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst/tx", tx, 1'b1);
        check("mid_rst/rdy", ifc.ready, 1'b1);
        check("mid_rst/busy", busy, 1'b0);
        check("mid_rst/done", frame_done, 1'b0);
        exp_q.delete();
        fd_q.delete();
        repeat (2) tick();
        check("in_rst/tx", tx, 1'b1);
        reset_n = 1'b1;
        tick();
        check_idle("after_rst");
        send_one("post_abort", DW'($urandom), 2'b01, 1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
